// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared encodings for the execute stage:
//   - ALU command codes
//   - barrel-shift type codes used by val2_gen
//   - forwarding-select encodings for the operand muxes
//   - NZCV status layout and a rotate helper
// ---------------------------------------------------------------------------
package exec_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_MOV = 4'b0001,
        ALU_MVN = 4'b1001,
        ALU_ADD = 4'b0010,
        ALU_ADC = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SBC = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000
    } alu_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_MEM     = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    // Bit 3 = N, bit 0 = V when viewed as a 4-bit vector.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Rotate right by 0..31; doubling the word avoids a (32 - amt) shift.
    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                                input logic [4:0]        amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/val2_gen.sv
// ---------------------------------------------------------------------------
// val2_gen
// Second ALU operand generator.
//   operand       : in  32  register operand (forwarded Rm)
//   shift_operand : in  12  immediate / shifter field from the instruction
//   imm           : in  1   shifter field holds a rotated 8-bit immediate
//   mem_access    : in  1   load/store: field is a plain 12-bit offset
//   val2          : out 32  resulting operand
// Priority: memory offset, then rotated immediate, then shifted register.
// ---------------------------------------------------------------------------
module val2_gen
    import exec_pkg::*;
(
    input  logic [DATA_W-1:0] operand,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_access,
    output logic [DATA_W-1:0] val2
);

    logic [4:0]        sh_amt;
    logic [1:0]        sh_type;
    logic [4:0]        rot_amt;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] shifted;

    assign sh_amt  = shift_operand[11:7];
    assign sh_type = shift_operand[6:5];
    // Immediate rotation is always an even amount: twice the 4-bit field.
    assign rot_amt = {shift_operand[11:8], 1'b0};

    always_comb begin
        imm_val = ror32({24'd0, shift_operand[7:0]}, rot_amt);
    end

    // A zero shift amount naturally passes the operand through for every type.
    always_comb begin
        shifted = operand;
        case (sh_type)
            SH_LSL:  shifted = operand << sh_amt;
            SH_LSR:  shifted = operand >> sh_amt;
            SH_ASR:  shifted = $unsigned($signed(operand) >>> sh_amt);
            SH_ROR:  shifted = ror32(operand, sh_amt);
            default: shifted = operand;
        endcase
    end

    always_comb begin
        if (mem_access) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = imm_val;
        end else begin
            val2 = shifted;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// ---------------------------------------------------------------------------
// exec_stage
// Execute stage of the 5-stage pipeline: operand forwarding, Val2 generation,
// ALU with NZCV status register, branch target computation and the EX/MEM
// pipeline register.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   pc_in .. s_in            : ID/EX control and PC
//   rn_val_in, rm_val_in     : register operands
//   imm_in, shift_operand_in : operand-2 selection / shifter field
//   imm24_in                 : signed branch word offset
//   dest_in, src1_in, src2_in: register numbers (sources used by hazard logic
//                              outside this block)
//   freeze                   : memory-stage stall, holds all state
//   mem_fwd_val, wb_fwd_val  : forwarded results
//   sel_src1, sel_src2       : forwarding selects (reg / MEM / WB / reg)
//   branch_taken, branch_addr, flush : combinational feedback to IF / ID
//   status                   : NZCV, bit 3 = N
//   alu_res_out .. mem_write_out     : EX/MEM register outputs
//
// Build option: define FORWARDING_EN to honour sel_src1/sel_src2. Without it
// the register operands are used directly and the forwarding ports are inert.
// ---------------------------------------------------------------------------
module exec_stage
    import exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic [31:0]        pc_in,
    input  logic [3:0]         alu_cmd_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               wb_en_in,
    input  logic               branch_in,
    input  logic               s_in,

    input  logic [31:0]        rn_val_in,
    input  logic [31:0]        rm_val_in,
    input  logic               imm_in,
    input  logic [11:0]        shift_operand_in,
    input  logic signed [23:0] imm24_in,
    input  logic [3:0]         dest_in,
    input  logic [3:0]         src1_in,
    input  logic [3:0]         src2_in,

    input  logic               freeze,

    input  logic [31:0]        mem_fwd_val,
    input  logic [31:0]        wb_fwd_val,
    input  logic [1:0]         sel_src1,
    input  logic [1:0]         sel_src2,

    output logic               branch_taken,
    output logic [31:0]        branch_addr,
    output logic               flush,

    output logic [3:0]         status,

    output logic [31:0]        alu_res_out,
    output logic [31:0]        store_val_out,
    output logic [3:0]         dest_out,
    output logic               wb_en_out,
    output logic               mem_read_out,
    output logic               mem_write_out
);

    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] val2;

    // ---------------- operand selection ----------------
`ifdef FORWARDING_EN
    always_comb begin
        case (sel_src1)
            FWD_MEM: op1 = mem_fwd_val;
            FWD_WB:  op1 = wb_fwd_val;
            default: op1 = rn_val_in;
        endcase
        case (sel_src2)
            FWD_MEM: op2 = mem_fwd_val;
            FWD_WB:  op2 = wb_fwd_val;
            default: op2 = rm_val_in;
        endcase
    end

    logic unused_src;
    assign unused_src = ^{src1_in, src2_in};
`else
    always_comb begin
        op1 = rn_val_in;
        op2 = rm_val_in;
    end

    logic unused_src;
    assign unused_src = ^{src1_in, src2_in, mem_fwd_val, wb_fwd_val,
                          sel_src1, sel_src2};
`endif

    val2_gen u_val2_gen (
        .operand       (op2),
        .shift_operand (shift_operand_in),
        .imm           (imm_in),
        .mem_access    (mem_read_in | mem_write_in),
        .val2          (val2)
    );

    // ---------------- state ----------------
    nzcv_t       status_q, status_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] store_val_q, store_val_d;
    logic [3:0]  dest_q, dest_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    // ---------------- ALU ----------------
    logic [31:0] alu_res;
    logic [32:0] sum33;
    logic        cmd_valid;
    logic        c_new;
    logic        v_new;
    nzcv_t       flags_new;

    always_comb begin
        alu_res   = '0;
        sum33     = '0;
        cmd_valid = 1'b1;
        // Logical and move ops leave C and V as they were.
        c_new     = status_q.c;
        v_new     = status_q.v;
        case (alu_cmd_in)
            ALU_MOV: alu_res = val2;
            ALU_MVN: alu_res = ~val2;
            ALU_AND: alu_res = op1 & val2;
            ALU_ORR: alu_res = op1 | val2;
            ALU_EOR: alu_res = op1 ^ val2;
            ALU_ADD, ALU_ADC: begin
                sum33 = {1'b0, op1} + {1'b0, val2}
                      + {32'd0, (alu_cmd_in == ALU_ADC) & status_q.c};
                alu_res = sum33[31:0];
                c_new   = sum33[32];
                v_new   = (op1[31] == val2[31]) && (alu_res[31] != op1[31]);
            end
            ALU_SUB, ALU_SBC: begin
                // a - b - borrow == a + ~b + carry_in; SUB uses carry_in = 1.
                sum33 = {1'b0, op1} + {1'b0, ~val2}
                      + {32'd0, (alu_cmd_in == ALU_SUB) | status_q.c};
                alu_res = sum33[31:0];
                c_new   = sum33[32];
                v_new   = (op1[31] != val2[31]) && (alu_res[31] != op1[31]);
            end
            default: cmd_valid = 1'b0;
        endcase

        if (cmd_valid) begin
            flags_new = '{n: alu_res[31], z: (alu_res == 32'd0), c: c_new, v: v_new};
        end else begin
            flags_new = status_q;
        end
    end

    // ---------------- branch ----------------
    always_comb begin
        branch_taken = branch_in;
        flush        = branch_in;
        branch_addr  = pc_in + {{6{imm24_in[23]}}, imm24_in, 2'b00};
    end

    // ---------------- next-state ----------------
    always_comb begin
        status_d    = status_q;
        alu_res_d   = alu_res_q;
        store_val_d = store_val_q;
        dest_d      = dest_q;
        wb_en_d     = wb_en_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (!freeze) begin
            if (s_in && !branch_in) begin
                status_d = flags_new;
            end
            alu_res_d   = alu_res;
            store_val_d = op2;
            dest_d      = dest_in;
            // A branch must not leave side effects in later stages.
            wb_en_d     = wb_en_in     & ~branch_in;
            mem_read_d  = mem_read_in  & ~branch_in;
            mem_write_d = mem_write_in & ~branch_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q    <= '0;
            alu_res_q   <= '0;
            store_val_q <= '0;
            dest_q      <= '0;
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            status_q    <= status_d;
            alu_res_q   <= alu_res_d;
            store_val_q <= store_val_d;
            dest_q      <= dest_d;
            wb_en_q     <= wb_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // ---------------- outputs ----------------
    assign status        = status_q;
    assign alu_res_out   = alu_res_q;
    assign store_val_out = store_val_q;
    assign dest_out      = dest_q;
    assign wb_en_out     = wb_en_q;
    assign mem_read_out  = mem_read_q;
    assign mem_write_out = mem_write_q;

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have inputs `pc_in` (32), `alu_cmd_in` (4), `mem_read_in`, `mem_write_in`, `wb_en_in`, `branch_in`, `s_in` (1 each): the ID/EX register outputs.
REQ-004 The block SHALL have inputs `rn_val_in`, `rm_val_in` (32 each), `imm_in` (1), `shift_operand_in` (12), `imm24_in` (24, signed), `dest_in` (4), `src1_in`, `src2_in` (4 each).
REQ-005 The block SHALL have input `freeze`, 1 bit: memory-stage stall; holds all state.
REQ-006 The block SHALL have inputs `mem_fwd_val`, `wb_fwd_val` (32 each) and `sel_src1`, `sel_src2` (2 each; 0=register, 1=MEM, 2=WB, 3=register): forwarding.
REQ-007 The block SHALL have outputs `branch_taken` (1), `branch_addr` (32) and `flush` (1), driven combinationally back to IF and to the ID/EX flush input.
REQ-008 The block SHALL have output `status` (4): the NZCV flags, bit 3 = N.
REQ-009 The block SHALL have EX/MEM outputs `alu_res_out` (32), `store_val_out` (32), `dest_out` (4), `wb_en_out`, `mem_read_out`, `mem_write_out` (1 each).

Function
REQ-010 ALU commands SHALL be: MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000; any other code SHALL yield result 0 with flags unchanged.
REQ-011 Val2 with `mem_read_in | mem_write_in`: the 12-bit offset `shift_operand_in`, zero-extended.
REQ-012 Val2 with `imm_in`=1: `shift_operand_in[7:0]` zero-extended and rotated right by 2×`shift_operand_in[11:8]`.
REQ-013 Val2 otherwise: the operand-2 value shifted by `shift_operand_in[11:7]` using type `[6:5]` (00 LSL, 01 LSR, 10 ASR, 11 ROR); a shift amount of 0 SHALL pass the value through unchanged.
REQ-014 Flags: N=res[31]; Z=(res==0).
- ADD/ADC: C = carry-out of the 33-bit sum.
- SUB/SBC: C = NOT borrow; SBC SHALL compute Rn−Val2−(1−C).
- V = signed overflow for arithmetic ops.
- Logical/move ops SHALL keep C and V unchanged.
REQ-015 The status register SHALL load the new NZCV on a rising edge when `s_in`=1, `freeze`=0 and `branch_in`=0.
REQ-016 `branch_taken` SHALL equal `branch_in`, with `branch_addr` = `pc_in` + (sign-extended `imm24_in` << 2), mod 2^32.
REQ-017 `flush` SHALL equal `branch_taken` in the same cycle.
REQ-018 The EX/MEM registers SHALL capture the ALU result, forwarded Rm, `dest_in`, `wb_en_in`, `mem_read_in` and `mem_write_in` on each rising edge with `freeze`=0: one-cycle latency.
REQ-019 With `freeze`=1 all registers SHALL hold.
REQ-020 If `branch_in` and `freeze` are both 1, `branch_taken` and `flush` SHALL still assert.
REQ-021 A branch SHALL load `wb_en_out`, `mem_read_out` and `mem_write_out` as 0.

Reset
REQ-022 While `rst`=0, `status`, all EX/MEM outputs and every internal register SHALL be 0.
REQ-023 Reset SHALL take effect immediately, independent of `clk`, including mid-freeze.
REQ-024 The first capture after release SHALL occur on the first rising edge with `rst`=1 and `freeze`=0.

Configuration
REQ-025 With `FORWARDING_EN` defined, the operand sources SHALL follow `sel_src1`/`sel_src2` per REQ-006.
REQ-026 Without `FORWARDING_EN`, `rn_val_in`/`rm_val_in` SHALL be used directly, the forwarding ports SHALL remain present, and those ports SHALL be ignored.

Structure
REQ-027 ALU command codes, shift-type codes and the forwarding-select encodings SHALL live in the shared package `exec_pkg`.
REQ-028 The Val2 computation (REQ-011..013) SHALL be the sub-module `val2_gen`.

Verification
REQ-029 ADD Rn=0x7FFFFFFF, imm 1, `s_in`=1 -> next cycle `alu_res_out`=0x80000000, `status`=1001.
REQ-030 SUB Rn=5, Val2=5, `s_in`=1 -> `alu_res_out`=0, `status`=0110; a following ADC 1+1 -> 3.
REQ-031 `imm_in`=1, `shift_operand_in`=0x4FF, MOV -> result 0xFF000000.
REQ-032 Register operand Rm=0x80000000, ASR #4 (0x240), MOV -> result 0xF8000000.
REQ-033 `branch_in`=1, `pc_in`=0x100, `imm24_in`=0xFFFFFE -> `branch_taken`=`flush`=1 and `branch_addr`=0x0F8 in the same cycle, with `wb_en_out`=0 next cycle.
REQ-034 `freeze`=1 for 3 cycles with changing inputs -> outputs constant; `rst` pulsed low mid-freeze -> all outputs 0 immediately.
